// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - enqueue handshake and decoder-drive bundle for wb_queue
//
// Purpose : groups the producer valid/ready push channel and the head-entry
//           signals driven toward the 3-to-8 write-port decoder.
// Signals : in_valid/in_ready/in_addr/in_data  - completed register write in
//           dec_in/dec_enable/wr_data          - head entry out to decoder
// Modports: master - producer / decoder side (testbench)
//           slave  - the queue itself
interface wb_queue_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_addr;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       dec_in;
    logic             dec_enable;
    logic [WIDTH-1:0] wr_data;

    modport master (
        output in_valid, in_addr, in_data,
        input  in_ready, dec_in, dec_enable, wr_data
    );

    modport slave (
        input  in_valid, in_addr, in_data,
        output in_ready, dec_in, dec_enable, wr_data
    );
endinterface

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - in-order write-back queue feeding the write-port decoder
//
// Purpose : buffers up to DEPTH completed register writes and retires one per
//           cycle by driving the decoder select/enable and write data.
// Ports   : clk, reset_n (async active-low)
//           bus (wb_queue_if.slave) - push handshake in, head entry to decoder
//           flush       - synchronous discard of every queued entry
//           drain_stall - hold the head entry this cycle
//           rd_addr     - forwarding lookup address
//           fwd_hit     - some queued entry targets rd_addr
//           fwd_data    - data of the youngest matching entry
//           count       - current occupancy 0..DEPTH
// Macro   : WBQ_FWD_EN - compiles in the forwarding comparators; when undefined
//           fwd_hit/fwd_data are tied to 0 and rd_addr is ignored.
module wb_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    wb_queue_if.slave                bus,
    input  logic                     flush,
    input  logic                     drain_stall,
    input  logic [2:0]               rd_addr,
    output logic                     fwd_hit,
    output logic [WIDTH-1:0]         fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // No pass-through when full: a same-cycle pop does not open a slot.
    assign bus.in_ready = ~w_full & ~flush;
    assign w_push       = bus.in_valid & bus.in_ready;
    assign w_pop        = ~w_empty & ~drain_stall & ~flush;

    assign bus.dec_enable = w_pop;
    assign bus.dec_in     = w_empty ? 3'd0 : r_addr[r_head];
    assign bus.wr_data    = w_empty ? '0   : r_data[r_head];
    assign count          = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset: empty slots are never observed because
    // the head outputs and the forwarding scan are both masked by occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.in_addr;
            r_data[r_tail] <= bus.in_data;
        end
    end

`ifdef WBQ_FWD_EN
    logic [PW-1:0]    w_fwd_idx;
    logic             w_fwd_hit;
    logic [WIDTH-1:0] w_fwd_data;

    // Scan oldest to youngest so a later match overrides an earlier one,
    // leaving the entry closest to the tail in w_fwd_data. The head entry is
    // included even when it is retiring this cycle.
    always_comb begin
        w_fwd_idx  = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fwd_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[w_fwd_idx] == rd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data[w_fwd_idx];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
`else
    logic w_unused_rd_addr;

    assign w_unused_rd_addr = ^rd_addr;
    assign fwd_hit          = 1'b0;
    assign fwd_data         = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// tb/tb_wb_queue.sv - directed self-checking bench for wb_queue
module tb_wb_queue;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
`ifdef WBQ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             drain_stall;
    logic [2:0]       rd_addr;
    logic             fwd_hit;
    logic [WIDTH-1:0] fwd_data;
    logic [2:0]       count;

    int checks;
    int errors;

    wb_queue_if #(.WIDTH(WIDTH)) bus ();

    wb_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .flush       (flush),
        .drain_stall (drain_stall),
        .rd_addr     (rd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        reset_n = 1'b0; bus.in_valid = 1'b1; bus.in_addr = 3'd5; bus.in_data = 64'hA5;
        flush = 1'b0; drain_stall = 1'b0; rd_addr = 3'd5;
        @(negedge clk); @(negedge clk);
        #1;
        checks++; if (count !== 3'd0) begin $display("FAIL rst_count_low got %0d exp 0", count); errors++; end
        checks++; if (bus.dec_enable !== 1'b0) begin $display("FAIL rst_dec_en_low got %b exp 0", bus.dec_enable); errors++; end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (count !== 3'd0) begin $display("FAIL rst_count got %0d exp 0", count); errors++; end
        checks++; if (bus.dec_enable !== 1'b0) begin $display("FAIL rst_dec_en got %b exp 0", bus.dec_enable); errors++; end
        checks++; if (bus.in_ready !== 1'b1) begin $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); errors++; end
        checks++; if (bus.dec_in !== 3'd0 || bus.wr_data !== 64'd0) begin $display("FAIL rst_dec_out got %0d/%h exp 0/0", bus.dec_in, bus.wr_data); errors++; end
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 64'd0) begin $display("FAIL rst_fwd got %b/%h exp 0/0", fwd_hit, fwd_data); errors++; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.dec_in !== 3'd5 || bus.dec_enable !== 1'b1 || bus.wr_data !== 64'hA5)
            begin $display("FAIL first_write got %0d/%b/%h exp 5/1/a5", bus.dec_in, bus.dec_enable, bus.wr_data); errors++; end
        checks++; if (count !== 3'd1) begin $display("FAIL first_count got %0d exp 1", count); errors++; end
        @(negedge clk);
        #1;
        checks++; if (count !== 3'd0 || bus.dec_enable !== 1'b0) begin $display("FAIL first_retired got %0d/%b exp 0/0", count, bus.dec_enable); errors++; end
    endtask

    task automatic test_fill;
        drain_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_addr = 3'(i); bus.in_data = 64'h100 + 64'(i);
            #1;
            checks++; if (bus.in_ready !== 1'b1 || count !== 3'(i - 1))
                begin $display("FAIL fill_%0d got ready %b count %0d exp 1/%0d", i, bus.in_ready, count, i - 1); errors++; end
        end
        @(negedge clk);
        bus.in_addr = 3'd7; bus.in_data = 64'h77;
        #1;
        checks++; if (count !== 3'd4 || bus.in_ready !== 1'b0) begin $display("FAIL full got count %0d ready %b exp 4/0", count, bus.in_ready); errors++; end
        checks++; if (bus.dec_enable !== 1'b0 || bus.dec_in !== 3'd1 || bus.wr_data !== 64'h101)
            begin $display("FAIL stall_head got %b/%0d/%h exp 0/1/101", bus.dec_enable, bus.dec_in, bus.wr_data); errors++; end
        @(negedge clk);
        bus.in_valid = 1'b0; drain_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) @(negedge clk);
            #1;
            checks++; if (bus.dec_in !== 3'(i) || bus.wr_data !== 64'h100 + 64'(i) || bus.dec_enable !== 1'b1 || count !== 3'(5 - i))
                begin $display("FAIL drain_%0d got %0d/%h/%b count %0d exp %0d/%h/1/%0d", i, bus.dec_in, bus.wr_data, bus.dec_enable, count, i, 64'h100 + 64'(i), 5 - i); errors++; end
        end
        @(negedge clk);
        #1;
        checks++; if (count !== 3'd0 || bus.dec_enable !== 1'b0 || bus.dec_in !== 3'd0)
            begin $display("FAIL drain_empty got %0d/%b/%0d exp 0/0/0", count, bus.dec_enable, bus.dec_in); errors++; end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k < 10) begin
                bus.in_valid = 1'b1; bus.in_addr = 3'(k % 8); bus.in_data = 64'h1000 + 64'(k);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (k == 0) begin
                checks++; if (count !== 3'd0) begin $display("FAIL b2b_start got %0d exp 0", count); errors++; end
            end else begin
                checks++; if (bus.dec_in !== 3'((k - 1) % 8) || bus.wr_data !== 64'h1000 + 64'(k - 1) || bus.dec_enable !== 1'b1 || count !== 3'd1)
                    begin $display("FAIL b2b_%0d got %0d/%h/%b count %0d exp %0d/%h/1/1", k, bus.dec_in, bus.wr_data, bus.dec_enable, count, (k - 1) % 8, 64'h1000 + 64'(k - 1)); errors++; end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (count !== 3'd0) begin $display("FAIL b2b_end got %0d exp 0", count); errors++; end
    endtask

    task automatic test_forward;
        logic             exp_hit;
        logic [WIDTH-1:0] exp_data;
        @(negedge clk);
        drain_stall = 1'b1; rd_addr = 3'd6;
        bus.in_valid = 1'b1; bus.in_addr = 3'd6; bus.in_data = 64'h11;
        #1;
        checks++; if (fwd_hit !== 1'b0) begin $display("FAIL fwd_empty got %b exp 0", fwd_hit); errors++; end
        @(negedge clk);
        bus.in_data = 64'h22;
        #1;
        exp_hit = FWD; exp_data = FWD ? 64'h11 : 64'h0;
        checks++; if (fwd_hit !== exp_hit || fwd_data !== exp_data)
            begin $display("FAIL fwd_one got %b/%h exp %b/%h", fwd_hit, fwd_data, exp_hit, exp_data); errors++; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        exp_data = FWD ? 64'h22 : 64'h0;
        checks++; if (fwd_hit !== exp_hit || fwd_data !== exp_data || count !== 3'd2)
            begin $display("FAIL fwd_youngest got %b/%h count %0d exp %b/%h/2", fwd_hit, fwd_data, count, exp_hit, exp_data); errors++; end
        rd_addr = 3'd5;
        #1;
        checks++; if (fwd_hit !== 1'b0 || fwd_data !== 64'h0) begin $display("FAIL fwd_miss got %b/%h exp 0/0", fwd_hit, fwd_data); errors++; end
        rd_addr = 3'd6; drain_stall = 1'b0;
        #1;
        checks++; if (bus.dec_in !== 3'd6 || bus.wr_data !== 64'h11 || fwd_hit !== exp_hit || fwd_data !== exp_data)
            begin $display("FAIL fwd_retire_old got %0d/%h fwd %b/%h exp 6/11 %b/%h", bus.dec_in, bus.wr_data, fwd_hit, fwd_data, exp_hit, exp_data); errors++; end
        @(negedge clk);
        #1;
        checks++; if (bus.dec_in !== 3'd6 || bus.wr_data !== 64'h22 || count !== 3'd1 || fwd_hit !== exp_hit || fwd_data !== exp_data)
            begin $display("FAIL fwd_retire_new got %0d/%h count %0d fwd %b/%h exp 6/22/1 %b/%h", bus.dec_in, bus.wr_data, count, fwd_hit, fwd_data, exp_hit, exp_data); errors++; end
        @(negedge clk);
        #1;
        checks++; if (fwd_hit !== 1'b0 || count !== 3'd0) begin $display("FAIL fwd_after got %b count %0d exp 0/0", fwd_hit, count); errors++; end
    endtask

    task automatic test_flush;
        drain_stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_addr = 3'(i); bus.in_data = 64'h30 + 64'(i);
        end
        @(negedge clk);
        bus.in_addr = 3'd7; bus.in_data = 64'h77; flush = 1'b1; drain_stall = 1'b0;
        #1;
        checks++; if (count !== 3'd3 || bus.in_ready !== 1'b0 || bus.dec_enable !== 1'b0)
            begin $display("FAIL flush_cycle got count %0d ready %b en %b exp 3/0/0", count, bus.in_ready, bus.dec_enable); errors++; end
        @(negedge clk);
        flush = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || bus.dec_enable !== 1'b0 || bus.dec_in !== 3'd0)
            begin $display("FAIL flush_after got %0d/%b/%0d exp 0/0/0", count, bus.dec_enable, bus.dec_in); errors++; end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.dec_enable !== 1'b0) begin $display("FAIL flush_quiet_%0d got %b exp 0", i, bus.dec_enable); errors++; end
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_addr = 3'd4; bus.in_data = 64'h44;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++; if (bus.dec_in !== 3'd4 || bus.wr_data !== 64'h44 || bus.dec_enable !== 1'b1)
            begin $display("FAIL flush_resume got %0d/%h/%b exp 4/44/1", bus.dec_in, bus.wr_data, bus.dec_enable); errors++; end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        drain_stall = 1'b1;
        for (int i = 2; i <= 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1; bus.in_addr = 3'(i); bus.in_data = 64'h50 + 64'(i);
        end
        @(negedge clk);
        bus.in_valid = 1'b0; drain_stall = 1'b0;
        #1;
        checks++; if (count !== 3'd2 || bus.dec_enable !== 1'b1 || bus.dec_in !== 3'd2)
            begin $display("FAIL mid_pre got count %0d en %b in %0d exp 2/1/2", count, bus.dec_enable, bus.dec_in); errors++; end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || bus.dec_enable !== 1'b0)
            begin $display("FAIL mid_async got count %0d en %b exp 0/0", count, bus.dec_enable); errors++; end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.dec_enable !== 1'b0 || count !== 3'd0)
                begin $display("FAIL mid_after_%0d got en %b count %0d exp 0/0", i, bus.dec_enable, count); errors++; end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        flush = 1'b0;
        drain_stall = 1'b0;
        rd_addr = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_addr = 3'd0;
        bus.in_data = '0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_forward();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
